// File: rtl/pes_elc_pkg.sv
// Shared definitions for the SCAN elevator car controller.
//   - elc_state_t : controller state encoding (IDLE, MOVE, DOOR_OPEN)
//   - DIR_UP / DIR_DOWN : direction encoding
//   - floor_span(): above/below masks for a one-hot floor position
// Masks are computed at ELC_MAX_FLOORS width. Callers zero-extend their
// vectors to that width, so NUM_FLOORS must not exceed ELC_MAX_FLOORS.
package pes_elc_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE      = 2'd1,
        DOOR_OPEN = 2'd2
    } elc_state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int ELC_MAX_FLOORS = 32;

    typedef struct packed {
        logic [ELC_MAX_FLOORS-1:0] above;
        logic [ELC_MAX_FLOORS-1:0] below;
    } elc_span_t;

    // For a one-hot position, below is every lower bit and above is every
    // higher bit. The position bit itself belongs to neither mask.
    function automatic elc_span_t floor_span(input logic [ELC_MAX_FLOORS-1:0] pos);
        elc_span_t span;
        span.below = pos - {{(ELC_MAX_FLOORS-1){1'b0}}, 1'b1};
        span.above = ~(span.below | pos);
        return span;
    endfunction

endpackage

// File: rtl/pes_elc_req_sched.sv
// Combinational request scheduler for the SCAN elevator controller.
// Ports:
//   i_pending   : outstanding floor requests
//   i_cur_floor : one-hot current floor
//   i_direction : travel direction (DIR_UP / DIR_DOWN)
//   o_hit_here  : a request is pending at the current floor
//   o_any_ahead : a request is pending in the travel direction
//   o_any_behind: a request is pending against the travel direction
module pes_elc_req_sched
    import pes_elc_pkg::*;
#(
    parameter int NUM_FLOORS = 8
) (
    input  logic [NUM_FLOORS-1:0] i_pending,
    input  logic [NUM_FLOORS-1:0] i_cur_floor,
    input  logic                  i_direction,
    output logic                  o_hit_here,
    output logic                  o_any_ahead,
    output logic                  o_any_behind
);

    logic [ELC_MAX_FLOORS-1:0] w_pend_ext;
    logic [ELC_MAX_FLOORS-1:0] w_cur_ext;
    elc_span_t                 w_span;
    logic                      w_any_above;
    logic                      w_any_below;

    assign w_pend_ext  = ELC_MAX_FLOORS'(i_pending);
    assign w_cur_ext   = ELC_MAX_FLOORS'(i_cur_floor);
    assign w_span      = floor_span(w_cur_ext);

    assign w_any_above = |(w_pend_ext & w_span.above);
    assign w_any_below = |(w_pend_ext & w_span.below);

    assign o_hit_here   = |(i_pending & i_cur_floor);
    assign o_any_ahead  = (i_direction == DIR_UP) ? w_any_above : w_any_below;
    assign o_any_behind = (i_direction == DIR_UP) ? w_any_below : w_any_above;

endmodule

// File: rtl/pes_elevator_scan.sv
// SCAN (sweep) elevator car controller.
// Requests accumulate in a pending mask and are served in sweep order.
// The car moves one floor every MOVE_CYCLES cycles. The door dwells for
// DOOR_CYCLES cycles, and that dwell is extended while an alert is active.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   req_valid/mask : floor request capture
//   over_time      : door obstructed / held too long
//   over_weight    : load exceeds limit
//   cur_floor      : one-hot floor position
//   direction      : 1 = up, 0 = down
//   moving         : car in motion
//   door_open      : door open
//   arrived        : single-cycle pulse on stopping at a requested floor
//   pending        : outstanding requests
//   door_alert     : registered over_time, only while idle or door open
//   weight_alert   : registered over_weight, only while idle or door open
module pes_elevator_scan
    import pes_elc_pkg::*;
#(
    parameter int NUM_FLOORS  = 8,
    parameter int MOVE_CYCLES = 2,
    parameter int DOOR_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [NUM_FLOORS-1:0] req_mask,
    input  logic                  over_time,
    input  logic                  over_weight,
    output logic [NUM_FLOORS-1:0] cur_floor,
    output logic                  direction,
    output logic                  moving,
    output logic                  door_open,
    output logic                  arrived,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  door_alert,
    output logic                  weight_alert
);

    localparam int MCW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
    localparam int DCW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [MCW-1:0]        MOVE_LAST  = MCW'(MOVE_CYCLES - 1);
    localparam logic [MCW-1:0]        MOVE_ONE   = MCW'(1);
    localparam logic [MCW-1:0]        MOVE_ZERO  = MCW'(0);
    localparam logic [DCW-1:0]        DOOR_LOAD  = DCW'(DOOR_CYCLES - 1);
    localparam logic [DCW-1:0]        DOOR_ONE   = DCW'(1);
    localparam logic [DCW-1:0]        DOOR_ZERO  = DCW'(0);
    localparam logic [NUM_FLOORS-1:0] FLOOR_ZERO = {NUM_FLOORS{1'b0}};
    localparam logic [NUM_FLOORS-1:0] FLOOR_BOT  = {{(NUM_FLOORS-1){1'b0}}, 1'b1};

    elc_state_t            r_state;
    logic [NUM_FLOORS-1:0] r_cur_floor;
    logic                  r_dir;
    logic [NUM_FLOORS-1:0] r_pending;
    logic [MCW-1:0]        r_move_cnt;
    logic [DCW-1:0]        r_door_cnt;
    logic                  r_moving;
    logic                  r_door_open;
    logic                  r_arrived;
    logic                  r_door_alert;
    logic                  r_weight_alert;

    logic [NUM_FLOORS-1:0] w_req;
    logic [NUM_FLOORS-1:0] w_next_floor;
    logic                  w_alert;
    logic                  w_here_req;
    logic                  w_hit_here;
    logic                  w_any_ahead;
    logic                  w_any_behind;

    assign w_req        = req_valid ? req_mask : FLOOR_ZERO;
    assign w_next_floor = (r_dir == DIR_UP) ? (r_cur_floor << 1) : (r_cur_floor >> 1);
    assign w_alert      = over_time | over_weight;
    assign w_here_req   = |(w_req & r_cur_floor);

    pes_elc_req_sched #(
        .NUM_FLOORS (NUM_FLOORS)
    ) u_sched (
        .i_pending    (r_pending),
        .i_cur_floor  (r_cur_floor),
        .i_direction  (r_dir),
        .o_hit_here   (w_hit_here),
        .o_any_ahead  (w_any_ahead),
        .o_any_behind (w_any_behind)
    );

    // Controller FSM: position, direction, request mask, counters and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_cur_floor    <= FLOOR_BOT;
            r_dir          <= DIR_UP;
            r_pending      <= FLOOR_ZERO;
            r_move_cnt     <= MOVE_ZERO;
            r_door_cnt     <= DOOR_ZERO;
            r_moving       <= 1'b0;
            r_door_open    <= 1'b0;
            r_arrived      <= 1'b0;
            r_door_alert   <= 1'b0;
            r_weight_alert <= 1'b0;
        end else begin
            r_arrived      <= 1'b0;
            // Alerts reflect the state the car is in while they are sampled.
            r_door_alert   <= over_time   & (r_state != MOVE);
            r_weight_alert <= over_weight & (r_state != MOVE);
            case (r_state)
                IDLE: begin
                    if (w_alert) begin
                        r_state     <= DOOR_OPEN;
                        r_door_open <= 1'b1;
                        r_door_cnt  <= DOOR_LOAD;
                        r_pending   <= r_pending | w_req;
                    end else if (w_hit_here) begin
                        // Serving this floor: a same-edge request for it is absorbed.
                        r_state     <= DOOR_OPEN;
                        r_door_open <= 1'b1;
                        r_door_cnt  <= DOOR_LOAD;
                        r_arrived   <= 1'b1;
                        r_pending   <= (r_pending | w_req) & ~r_cur_floor;
                    end else if (w_any_ahead) begin
                        r_state     <= MOVE;
                        r_moving    <= 1'b1;
                        r_move_cnt  <= MOVE_ZERO;
                        r_pending   <= r_pending | w_req;
                    end else if (w_any_behind) begin
                        // Reversal happens only here, never mid-sweep.
                        r_dir       <= ~r_dir;
                        r_state     <= MOVE;
                        r_moving    <= 1'b1;
                        r_move_cnt  <= MOVE_ZERO;
                        r_pending   <= r_pending | w_req;
                    end else begin
                        r_pending   <= r_pending | w_req;
                    end
                end
                MOVE: begin
                    if (r_move_cnt == MOVE_LAST) begin
                        r_move_cnt  <= MOVE_ZERO;
                        r_cur_floor <= w_next_floor;
                        if (|(r_pending & w_next_floor)) begin
                            r_state     <= DOOR_OPEN;
                            r_moving    <= 1'b0;
                            r_door_open <= 1'b1;
                            r_door_cnt  <= DOOR_LOAD;
                            r_arrived   <= 1'b1;
                            r_pending   <= (r_pending | w_req) & ~w_next_floor;
                        end else begin
                            r_pending   <= r_pending | w_req;
                        end
                    end else begin
                        r_move_cnt <= r_move_cnt + MOVE_ONE;
                        r_pending  <= r_pending | w_req;
                    end
                end
                DOOR_OPEN: begin
                    // The door is already open here, so a call for this floor is served directly.
                    r_pending <= (r_pending | w_req) & ~r_cur_floor;
                    if (w_alert || w_here_req) begin
                        r_door_cnt <= DOOR_LOAD;
                    end else if (r_door_cnt == DOOR_ZERO) begin
                        r_state     <= IDLE;
                        r_door_open <= 1'b0;
                    end else begin
                        r_door_cnt <= r_door_cnt - DOOR_ONE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_moving    <= 1'b0;
                    r_door_open <= 1'b0;
                    r_move_cnt  <= MOVE_ZERO;
                    r_door_cnt  <= DOOR_ZERO;
                end
            endcase
        end
    end

    assign cur_floor    = r_cur_floor;
    assign direction    = r_dir;
    assign moving       = r_moving;
    assign door_open    = r_door_open;
    assign arrived      = r_arrived;
    assign pending      = r_pending;
    assign door_alert   = r_door_alert;
    assign weight_alert = r_weight_alert;

endmodule

// File: doc/pes_elevator_scan.md
Name: pes_elevator_scan

Overview:
- Parametrised next-generation car controller for an N-floor elevator.
- Floor position is kept as a one-hot vector.
- Requests are latched into a pending mask and served in SCAN (sweep) order, with a timed move between floors and a timed door-open dwell.
- over_time / over_weight hold the door open and raise alerts. Sits between the call-button aggregation logic and the motor/door drivers.

Parameters:
- NUM_FLOORS, 8, number of floors; one-hot vector width; must be ≥ 2.
- MOVE_CYCLES, 2, clock cycles to travel one floor; must be ≥ 1.
- DOOR_CYCLES, 4, cycles door remains open with no alert; must be ≥ 1.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high; clock clk
- req_valid  in  1  req_mask is valid this cycle
- req_mask  in  NUM_FLOORS  floor requests, any number of bits set
- over_time  in  1  door obstructed / held too long
- over_weight  in  1  load exceeds limit
- cur_floor  out  NUM_FLOORS  one-hot current floor
- direction  out  1  1 = up, 0 = down (last/planned travel direction)
- moving  out  1  car in motion
- door_open  out  1  door open
- arrived  out  1  single-cycle pulse on stopping at a requested floor
- pending  out  NUM_FLOORS  outstanding requests
- door_alert  out  1  over_time active while door open/idle
- weight_alert  out  1  over_weight active while door open/idle

Behaviour:
- Reset values:
  - cur_floor = 1 (floor 0), direction = 1, state = IDLE, pending = 0.
  - moving, door_open, arrived, door_alert and weight_alert all 0.
  - move_cnt = 0, door_cnt = 0.
  - Reset mid-operation returns all state to these values at the next edge.
- Request capture: when req_valid, pending |= req_mask at the edge, except the current-floor bit while in DOOR_OPEN or on an arrival edge; that bit is serviced instead, and clear wins over set.
- States:
  - IDLE:
    - door closed, not moving.
    - If over_time or over_weight → DOOR_OPEN.
    - Else if pending has the cur_floor bit → DOOR_OPEN, clear bit, arrived = 1.
    - Else if pending has bits in current direction → MOVE.
    - Else if pending has bits in the opposite direction → flip direction, MOVE.
    - Else stay.
  - MOVE:
    - moving = 1. move_cnt counts 0..MOVE_CYCLES-1.
    - At terminal count, cur_floor shifts one position (left if up, right if down) and move_cnt = 0.
    - If the new floor's pending bit is set → DOOR_OPEN the same edge, clear bit, arrived pulse next cycle.
    - Otherwise continue MOVE.
    - Alerts are ignored in MOVE.
    - cur_floor must never shift out of range; a bench assertion is required.
  - DOOR_OPEN:
    - door_open = 1. door_cnt loads DOOR_CYCLES-1 on entry and decrements.
    - door_cnt reloads whenever an alert is active or a current-floor request arrives.
    - At door_cnt = 0 with no alert → IDLE (door closes).
- Alerts:
  - door_alert = over_time and weight_alert = over_weight, registered, only in IDLE/DOOR_OPEN; otherwise 0.
  - Both alerts may be high together.
- SCAN:
  - "Above" = pending bits at higher index than cur_floor; "below" = lower index.
  - Direction is held while requests remain ahead.
  - Direction reverses only in IDLE.
  - At the top floor there is nothing above, so the car reverses; symmetric at floor 0.
- Latency from request capture edge k to first move:
  - State is MOVE after edge k+1.
  - The first floor step occurs at edge k+1+MOVE_CYCLES.

Decomposition:
- Package pes_elc_pkg holds:
  - state enum (IDLE, MOVE, DOOR_OPEN);
  - DIR_UP = 1 / DIR_DOWN = 0;
  - a function giving the above/below masks for a one-hot position.
- Sub-module pes_elc_req_sched:
  - combinational; takes pending, cur_floor and direction;
  - returns hit_here, any_ahead, any_behind.
- Top module holds the FSM, counters and registers.

Test Plan (NUM_FLOORS=8, MOVE_CYCLES=2, DOOR_CYCLES=4):
1. Reset held 2 cycles → cur_floor=8'h01, pending=0, all flags 0, direction=1.
2. At floor 0, req_mask=8'h08 for 1 cycle (edge k) → pending=8'h08; moving from k+1; cur_floor 8'h02/8'h04/8'h08 at k+3/k+5/k+7; arrived pulse once; door_open 4 cycles; pending=0.
3. Car at floor 2 moving up to floor 6; inject 8'h12 (floors 1 and 4) → stops at 4, then 6, then reverses and stops at 1; arrived pulses in that order.
4. Door open at floor 3; over_weight high 10 cycles → door_open and weight_alert held throughout; door closes 4 cycles after deassert.
5. Door open, door_cnt=1, req_mask=cur_floor → pending bit stays 0, door_cnt reloads to 3, door open 3 extra cycles.
6. Reset asserted mid-MOVE between floors 4 and 5 → next edge: cur_floor=8'h01, IDLE, pending=0, moving=0.
